// File: rtl/arbiter8_rr_enc_if.sv
// Request/grant bundle between the eight requesters and the round-robin arbiter.
// The arbiter side uses the slave modport; the requester side uses master.
interface arbiter8_rr_enc_if;
  logic       en;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  modport master (
    output en, req, done,
    input  gnt, gnt_idx, gnt_valid, timeout
  );

  modport slave (
    input  en, req, done,
    output gnt, gnt_idx, gnt_valid, timeout
  );
endinterface

// File: rtl/arbiter8_rr_enc.sv
// Eight-way round-robin arbiter with registered one-hot and 8:3-encoded grant.
// Optional hold-limit revocation is compiled in with `define ARB_TIMEOUT_EN.
module arbiter8_rr_enc #(
  parameter int HOLD_MAX = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  arbiter8_rr_enc_if.slave  bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state, state_nxt;
  logic [2:0] ptr, ptr_nxt;
  logic [7:0] gnt_nxt;
  logic [3:0] pick;
  logic       release_cond;
  logic       hold_limit;

  if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_bad_hold
    $error("arbiter8_rr_enc: HOLD_MAX must be within 1..255");
  end

  // First set request at or after ptr, wrapping; returns {found, index}.
  function automatic logic [3:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
    logic [3:0] res;
    logic [2:0] c;
    res = 4'b0000;
    for (int i = 7; i >= 0; i--) begin
      c = p + 3'(i);
      if (r[c]) res = {1'b1, c};
    end
    return res;
  endfunction

  function automatic logic [2:0] enc8to3(input logic [7:0] y);
    return {y[7] | y[6] | y[5] | y[4],
            y[7] | y[6] | y[3] | y[2],
            y[7] | y[5] | y[3] | y[1]};
  endfunction

  assign pick         = rr_pick(bus.req, ptr);
  assign release_cond = bus.done | ~bus.req[bus.gnt_idx] | ~bus.en;

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);
  logic [7:0] hold_cnt;

  assign hold_limit = (hold_cnt == HOLD_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt    <= 8'd0;
      bus.timeout <= 1'b0;
    end else begin
      hold_cnt    <= (state == GRANT) ? hold_cnt + 8'd1 : 8'd0;
      bus.timeout <= (state == GRANT) & hold_limit & ~release_cond;
    end
  end
`else
  assign hold_limit  = 1'b0;
  assign bus.timeout = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    gnt_nxt   = bus.gnt;
    unique case (state)
      IDLE: begin
        if (bus.en && pick[3]) begin
          state_nxt = GRANT;
          gnt_nxt   = 8'b1 << pick[2:0];
        end
      end
      GRANT: begin
        if (release_cond || hold_limit) begin
          state_nxt = IDLE;
          gnt_nxt   = 8'h00;
          // Dropping en parks the pointer so the same owner wins again.
          if (bus.en) ptr_nxt = bus.gnt_idx + 3'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      ptr           <= 3'd0;
      bus.gnt       <= 8'h00;
      bus.gnt_idx   <= 3'd0;
      bus.gnt_valid <= 1'b0;
    end else begin
      state         <= state_nxt;
      ptr           <= ptr_nxt;
      bus.gnt       <= gnt_nxt;
      bus.gnt_idx   <= enc8to3(gnt_nxt);
      bus.gnt_valid <= (state_nxt == GRANT);
    end
  end

endmodule

// File: doc/arbiter8_rr_enc.md
# arbiter8_rr_enc

Round-robin arbiter that shares a single downstream resource among eight requesters and reports the owner both as a one-hot grant vector and as a 3-bit encoded index, using the same Y7..Y0 → A2..A1..A0 encoding as the team's 8:3 encoder. It sits in front of the shared resource and sequences ownership: one owner at a time, fair rotation, explicit release. Grant outputs are fully registered.

## Interface
Parameters:
- HOLD_MAX, 16, maximum grant duration in cycles, legal range 1..255; used only when ARB_TIMEOUT_EN is defined.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  arbiter enable.
- req  input  8  request lines; bit i belongs to requester i.
- done  input  1  release strobe from the current owner.
- gnt  output  8  one-hot grant, or all zero when there is no owner.
- gnt_idx  output  3  encoded owner index (A2..A0); 0 when there is no owner.
- gnt_valid  output  1  high while an owner holds the resource.
- timeout  output  1  one-cycle pulse when a grant is revoked by the hold limit.

## Operation
- Reset values: state = IDLE, gnt = 8'h00, gnt_idx = 0, gnt_valid = 0, timeout = 0, rotation pointer ptr = 0, hold counter = 0.
- Two states, IDLE and GRANT.
- **IDLE → GRANT**
  - Taken when en = 1 and req != 0.
  - Winner is the first set bit of req searching ptr, ptr+1, …, 7, 0, …, ptr−1 (mod 8).
  - On the same edge: gnt = one-hot(winner), gnt_idx = winner, gnt_valid = 1.
- **GRANT → IDLE (release)**
  - Taken on any of: done = 1, req[gnt_idx] = 0, or en = 0.
  - On that edge: gnt, gnt_idx and gnt_valid clear.
  - ptr is set to gnt_idx + 1 (wraps 7 → 0) on release and on timeout, but not when the cause is en = 0.
- **GRANT hold**
  - No other condition changes gnt.
  - Requests from other requesters are ignored while a grant is held; there is no preemption.
- **Simultaneous events**
  - done and req[gnt_idx] = 0 in the same cycle count as a single release.
  - A release always returns to IDLE first. Re-arbitration starts in the following cycle, giving one dead cycle between owners.
- **en = 0 in IDLE**: no grant is issued; req is ignored.
- **Reset mid-grant**: all outputs clear immediately (asynchronously) and ptr returns to 0.
- **Encoding invariant**: whenever gnt_valid = 1, gnt_idx equals the 8:3 encoding of gnt.

## Timing
- Request to grant: req sampled high in IDLE at edge k gives gnt valid after edge k (1-cycle latency).
- Release to gnt low: done sampled at edge k gives gnt = 0 after edge k.
- Owner-to-owner minimum gap: 1 cycle with gnt_valid = 0.
- A requester that holds req high continuously is re-granted after at most 7 other grants.
- All outputs are registered; there is no combinational path from req, done or en to any output.

## Configuration
- Macro: ARB_TIMEOUT_EN.
- **Defined**:
  - An 8-bit hold counter clears on entry to GRANT and increments each GRANT cycle.
  - If the counter equals HOLD_MAX−1 and no release condition is present, the next edge forces GRANT → IDLE and ptr = gnt_idx + 1.
  - timeout = 1 for exactly the first cycle in which gnt = 0; otherwise timeout = 0.
  - A release condition in the same cycle as the limit takes precedence: timeout stays 0.
- **Not defined**:
  - No counter logic is present.
  - timeout is tied to 0.
  - Grants are held indefinitely until a release condition occurs.

## Test plan
- **Reset**: drive rst_n low mid-grant. Outputs must read 0 asynchronously. After reset, apply req = 8'h80, en = 1: gnt = 8'h80, gnt_idx = 7 one cycle later.
- **Rotation**: hold req = 8'hFF with en = 1 and pulse done after each grant. The gnt_idx sequence must be 0,1,2,…,7,0, with exactly one idle cycle between grants.
- **Skip and wrap**: ptr = 6 (after a grant to 5 is released), req = 8'h05. Grant must go to 0 (gnt_idx = 0), then to 2 on the next arbitration.
- **Implicit release and no preemption**:
  - Owner 3 drops req[3] while req[6] is high: gnt clears next cycle, then gnt = 8'h40.
  - While 3 is owner, req[1] must not disturb the grant.
- **Enable**: deassert en during a grant to 4. gnt must clear next cycle and ptr must stay unchanged, so with req = 8'hFF and en re-asserted the grant goes to 4 again.
- **Timeout** (ARB_TIMEOUT_EN, HOLD_MAX = 4):
  - Owner 2 holds req with no done: gnt stays 8'h04 for exactly 4 cycles, then gnt = 0 with a one-cycle timeout pulse, and the next grant starts search at 3.
  - Build without the macro: the grant persists for more than 100 cycles and timeout stays 0.
